// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
//   state_e   : sequencer states (load A, load B, load opcode, execute, show)
//   OP_*      : ALU opcode encodings driven on Op
//   FLAG_*    : bit positions of Z/N/C/V inside the 4-bit flag vector
package alu_seq_pkg;

  typedef enum logic [2:0] {
    StLoadA  = 3'd0,
    StLoadB  = 3'd1,
    StLoadOp = 3'd2,
    StExec   = 3'd3,
    StShow   = 3'd4
  } state_e;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // One-hot stage LED patterns.
  localparam logic [3:0] STAGE_LOAD_A  = 4'b0001;
  localparam logic [3:0] STAGE_LOAD_B  = 4'b0010;
  localparam logic [3:0] STAGE_LOAD_OP = 4'b0100;
  localparam logic [3:0] STAGE_SHOW    = 4'b1000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, level debouncer, rising-edge detector.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   btn        : raw active-high button input (asynchronous)
//   pulse      : one-cycle pulse per accepted press
// A level is accepted only after DEBOUNCE_CYCLES consecutive samples differ from the
// current stable level; any sample matching the stable level restarts the count.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            stable_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchronizer, stable level and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= btn;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign pulse = stable_q & ~stable_prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Front-end sequencer for the board's 4-bit ALU.
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   sw[3:0]             : switch bank, source of A, B and Op
//   btn_next, btn_clear : raw push-buttons (advance / return to start)
//   A, B, Op            : registered operands and opcode driving the external ALU
//   alu_R, alu_flags    : combinational ALU result and {Z,N,C,V} flags
//   res_R, res_flags    : result and flags latched one cycle after Op loads
//   res_valid           : res_* belong to the current A/B/Op
//   stage               : one-hot LED stage indicator (EXEC shows as SHOW)
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_next,
  input  logic       btn_clear,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [1:0] Op,
  input  logic [3:0] alu_R,
  input  logic [3:0] alu_flags,
  output logic [3:0] res_R,
  output logic [3:0] res_flags,
  output logic       res_valid,
  output logic [3:0] stage
);

  logic next_p, clear_p;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next_db (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_next),
    .pulse(next_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_clear),
    .pulse(clear_p)
  );

  state_e state_q, state_d;

  logic [3:0] a_q, b_q, res_r_q, res_flags_q;
  logic [1:0] op_q;
  logic       res_valid_q;

  logic load_a, load_b, load_op, capture_res, drop_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoadA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear wins over next, and EXEC never waits for a button.
  always_comb begin
    state_d = state_q;
    if (clear_p) begin
      state_d = StLoadA;
    end else begin
      unique case (state_q)
        StLoadA:  if (next_p) state_d = StLoadB;
        StLoadB:  if (next_p) state_d = StLoadOp;
        StLoadOp: if (next_p) state_d = StExec;
        StExec:   state_d = StShow;
        StShow:   if (next_p) state_d = StLoadA;
        default:  state_d = StLoadA;
      endcase
    end
  end

  // Output decode: register enables and the stage LEDs.
  always_comb begin
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_op     = 1'b0;
    capture_res = 1'b0;
    drop_valid  = 1'b0;
    stage       = STAGE_LOAD_A;
    unique case (state_q)
      StLoadA: begin
        load_a = next_p & ~clear_p;
        stage  = STAGE_LOAD_A;
      end
      StLoadB: begin
        load_b = next_p & ~clear_p;
        stage  = STAGE_LOAD_B;
      end
      StLoadOp: begin
        load_op = next_p & ~clear_p;
        stage   = STAGE_LOAD_OP;
      end
      StExec: begin
        capture_res = ~clear_p;
        stage       = STAGE_SHOW;
      end
      StShow: begin
        drop_valid = next_p & ~clear_p;
        stage      = STAGE_SHOW;
      end
      default: stage = STAGE_LOAD_A;
    endcase
  end

  // Operand, opcode and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_r_q     <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
    end else if (clear_p) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_r_q     <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (load_a)  a_q  <= sw;
      if (load_b)  b_q  <= sw;
      if (load_op) op_q <= sw[1:0];
      if (capture_res) begin
        res_r_q     <= alu_R;
        res_flags_q <= alu_flags;
        res_valid_q <= 1'b1;
      end else if (drop_valid) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign Op        = op_q;
  assign res_R     = res_r_q;
  assign res_flags = res_flags_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

  localparam int unsigned Deb = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn_next, btn_clear;
  logic [3:0] A, B;
  logic [1:0] Op;
  logic [3:0] alu_R, alu_flags;
  logic [3:0] res_R, res_flags;
  logic       res_valid;
  logic [3:0] stage;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .btn_next (btn_next),
    .btn_clear(btn_clear),
    .A        (A),
    .B        (B),
    .Op       (Op),
    .alu_R    (alu_R),
    .alu_flags(alu_flags),
    .res_R    (res_R),
    .res_flags(res_flags),
    .res_valid(res_valid),
    .stage    (stage)
  );

  // ALU model: result plus {Z,N,C,V} (C = carry-out for SUB, high-half nonzero for MUL).
  logic [4:0] m_sum;
  logic [7:0] m_prod;
  logic [3:0] m_r;
  logic       m_c, m_v;
  always_comb begin
    m_sum  = {1'b0, A} + {1'b0, ~B} + 5'd1;
    m_prod = {4'b0, A} * {4'b0, B};
    m_r    = 4'h0;
    m_c    = 1'b0;
    m_v    = 1'b0;
    case (Op)
      2'b00: m_r = A & B;
      2'b01: m_r = A ^ B;
      2'b10: begin
        m_r = m_sum[3:0];
        m_c = m_sum[4];
        m_v = (A[3] != B[3]) && (m_sum[3] != A[3]);
      end
      default: begin
        m_r = m_prod[3:0];
        m_c = |m_prod[7:4];
      end
    endcase
  end
  assign alu_R     = m_r;
  assign alu_flags = {(m_r == 4'h0), m_r[3], m_c, m_v};

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] r;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Called at posedge+1; returns edges until stage changes (30 = timed out).
  task automatic wait_change(output int lat);
    logic [3:0] old;
    old = stage;
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (stage != old) break;
    end
  endtask

  task automatic press(input logic nxt, input logic clr, input logic [3:0] v, output int lat);
    @(posedge clk);
    #1;
    sw        = v;
    btn_next  = nxt;
    btn_clear = clr;
    wait_change(lat);
  endtask

  task automatic release_btns();
    btn_next  = 1'b0;
    btn_clear = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int changes;
    logic [3:0] prev;

    vecs[0] = '{a: 4'd5,  b: 4'd3,  op: 2'b10, r: 4'd2,  flags: 4'b0010};
    vecs[1] = '{a: 4'd12, b: 4'd10, op: 2'b00, r: 4'd8,  flags: 4'b0100};
    vecs[2] = '{a: 4'd6,  b: 4'd6,  op: 2'b01, r: 4'd0,  flags: 4'b1000};
    vecs[3] = '{a: 4'd3,  b: 4'd5,  op: 2'b10, r: 4'd14, flags: 4'b0100};
    vecs[4] = '{a: 4'd7,  b: 4'd3,  op: 2'b11, r: 4'd5,  flags: 4'b0010};
    vecs[5] = '{a: 4'd7,  b: 4'd15, op: 2'b10, r: 4'd8,  flags: 4'b0101};

    rst_n     = 1'b0;
    sw        = 4'h0;
    btn_next  = 1'b0;
    btn_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_A", A, 0);
    check("reset_B", B, 0);
    check("reset_Op", Op, 0);
    check("reset_res_R", res_R, 0);
    check("reset_res_flags", res_flags, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_stage", stage, 4'b0001);
    #2 rst_n = 1'b1;

    // Bounce: 3 high, 1 low, 2 high -> never accepted.
    @(posedge clk);
    #1;
    sw = 4'hA;
    btn_next = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn_next = 1'b0;
    @(posedge clk);
    #1 btn_next = 1'b1;
    repeat (2) @(posedge clk);
    #1 btn_next = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("bounce_stage", stage, 4'b0001);
    check("bounce_A", A, 0);

    // Held for 40 cycles -> exactly one advance.
    btn_next = 1'b1;
    changes  = 0;
    lat      = 0;
    prev     = stage;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (stage != prev) begin
        changes++;
        if (lat == 0) lat = i;
      end
      prev = stage;
    end
    check("held_advances", changes, 1);
    check_range("held_latency", lat, 5, 7);
    check("held_A", A, 4'hA);
    check("held_stage", stage, 4'b0010);
    release_btns();

    // Clear from LOAD_B.
    press(1'b0, 1'b1, 4'h0, lat);
    check("clear_lb_stage", stage, 4'b0001);
    check("clear_lb_A", A, 0);
    release_btns();

    for (int i = 0; i < 6; i++) begin
      check("vec_start_stage", stage, 4'b0001);
      press(1'b1, 1'b0, vecs[i].a, lat);
      check_range("vec_a_latency", lat, 5, 7);
      check("vec_A", A, vecs[i].a);
      check("vec_stage_b", stage, 4'b0010);
      release_btns();
      press(1'b1, 1'b0, vecs[i].b, lat);
      check("vec_B", B, vecs[i].b);
      check("vec_stage_op", stage, 4'b0100);
      release_btns();
      press(1'b1, 1'b0, {2'b00, vecs[i].op}, lat);
      check("vec_Op", Op, vecs[i].op);
      check("vec_exec_stage", stage, 4'b1000);
      check("vec_exec_valid", res_valid, 0);
      @(posedge clk);
      #1;
      check("vec_res_R", res_R, vecs[i].r);
      check("vec_res_flags", res_flags, vecs[i].flags);
      check("vec_res_valid", res_valid, 1);
      check("vec_show_stage", stage, 4'b1000);
      release_btns();
      sw = ~vecs[i].a;
      repeat (3) @(posedge clk);
      #1;
      check("vec_hold_A", A, vecs[i].a);
      check("vec_hold_B", B, vecs[i].b);
      check("vec_hold_Op", Op, vecs[i].op);
      check("vec_show_hold", stage, 4'b1000);
      // Wrap back to LOAD_A; result retained, valid dropped.
      press(1'b1, 1'b0, 4'h9, lat);
      check("wrap_stage", stage, 4'b0001);
      check("wrap_valid", res_valid, 0);
      check("wrap_res_R", res_R, vecs[i].r);
      check("wrap_A", A, vecs[i].a);
      release_btns();
    end

    press(1'b1, 1'b0, 4'h9, lat);
    check("after_wrap_A", A, 4'h9);
    check("after_wrap_res_R", res_R, vecs[5].r);
    release_btns();
    press(1'b1, 1'b0, 4'h3, lat);
    check("prio_setup_stage", stage, 4'b0100);
    release_btns();

    // Clear and next together in LOAD_OP: clear wins, Op not loaded.
    press(1'b1, 1'b1, 4'h3, lat);
    check("prio_stage", stage, 4'b0001);
    check("prio_A", A, 0);
    check("prio_B", B, 0);
    check("prio_Op", Op, 0);
    check("prio_res_R", res_R, 0);
    check("prio_res_flags", res_flags, 0);
    check("prio_res_valid", res_valid, 0);
    repeat (5) @(posedge clk);
    #1;
    check("prio_after_stage", stage, 4'b0001);
    release_btns();

    // Reset in LOAD_B with btn_next held.
    press(1'b1, 1'b0, 4'h6, lat);
    check("rst_setup_A", A, 4'h6);
    repeat (5) @(posedge clk);
    #1;
    check("rst_held_stage", stage, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_A", A, 0);
    check("rst_async_stage", stage, 4'b0001);
    @(posedge clk);
    #1;
    sw = 4'h7;
    #2 rst_n = 1'b1;
    #1;
    wait_change(lat);
    check_range("rst_release_latency", lat, 5, 8);
    check("rst_release_stage", stage, 4'b0010);
    check("rst_release_A", A, 4'h7);
    release_btns();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end sequencer for the 4-bit ALU on the FPGA board. It debounces two push-buttons and loads operand A, operand B and the 2-bit opcode from a 4-bit switch bank, one button press at a time. It drives the registered A/B/Op into the combinational ALU and latches the ALU result and Z/N/C/V flags for the display/LED stage. It sits directly upstream of the ALU and also captures its outputs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000, number of consecutive stable samples required to accept a button level (5 ms at 50 MHz); minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous and active-low.
- sw  in  4  raw switch bank, used as the operand/opcode source.
- btn_next  in  1  raw push-button, active-high, advances the sequence.
- btn_clear  in  1  raw push-button, active-high, returns to the start.
- A  out  4  registered operand A to the ALU.
- B  out  4  registered operand B to the ALU.
- Op  out  2  registered opcode to the ALU (00 AND, 01 XOR, 10 SUB, 11 MUL).
- alu_R  in  4  ALU result.
- alu_flags  in  4  ALU flags {Z,N,C,V}.
- res_R  out  4  latched result.
- res_flags  out  4  latched flags {Z,N,C,V}.
- res_valid  out  1  high while res_R/res_flags hold a result of the current A/B/Op.
- stage  out  4  one-hot LED indicator: [0] LOAD_A, [1] LOAD_B, [2] LOAD_OP, [3] SHOW.

## Operation
- Both buttons use the same conditioning path:
  - 2-FF synchronizer, then a debouncer, then a rising-edge detector.
  - Each accepted press yields exactly one 1-cycle pulse: next_p or clear_p.
- Debouncer behaviour:
  - Holds a stable level, reset 0.
  - A counter increments while the synchronized input differs from the stable level.
  - The counter resets to 0 whenever the input equals the stable level.
  - When the count reaches DEBOUNCE_CYCLES-1 with the input still differing, the stable level flips and the counter clears.
- State machine states: LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW. Reset state is LOAD_A.
- Transitions:
  - LOAD_A + next_p: A <= sw, go to LOAD_B.
  - LOAD_B + next_p: B <= sw, go to LOAD_OP.
  - LOAD_OP + next_p: Op <= sw[1:0], go to EXEC.
  - EXEC (always exactly 1 cycle): res_R <= alu_R, res_flags <= alu_flags, res_valid <= 1, go to SHOW.
  - SHOW + next_p: res_valid <= 0, go to LOAD_A. A, B, Op and res_* keep their values.
- clear_p in any state:
  - Go to LOAD_A.
  - A, B, Op, res_R, res_flags and res_valid all go to 0.
  - clear_p has priority over next_p when both occur in the same cycle.
- In EXEC, a next_p is ignored (lost). A clear_p still applies.
- A/B/Op change only on the transitions listed above. sw changes at any other time have no effect.
- stage is decoded from the state. EXEC displays as SHOW (stage = 4'b1000).

## Timing
- All outputs are 0 during and after reset, except stage = 4'b0001.
- Reset asserted mid-sequence:
  - Clears everything immediately (asynchronous), including synchronizers, debounce counters and stable levels.
  - A button held through reset release counts as a new press once it has been stable for DEBOUNCE_CYCLES.
- Press latency:
  - A raw rising edge held steady produces its pulse 2 + DEBOUNCE_CYCLES cycles later (±1 for input phase).
  - The register update occurs on the clock edge that ends the pulse cycle.
- Result latency:
  - Op is registered on edge k.
  - The ALU settles combinationally during cycle k→k+1.
  - res_* and res_valid are registered on edge k+1.
  - SHOW begins at k+1.
- A held button advances exactly once. A new press requires release (stable for DEBOUNCE_CYCLES) and then a new stable press.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse.

## Structure
- Package alu_seq_pkg holds:
  - the state enum (LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW);
  - opcode constants OP_AND/OP_XOR/OP_SUB/OP_MUL;
  - flag index constants FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
- Sub-module btn_debounce (synchronizer + debouncer + edge detect, parameter DEBOUNCE_CYCLES, output 1-cycle pulse), instantiated twice.
- The ALU is not instantiated inside this block. It is connected at the top level.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4. The bench models the ALU as alu_R = f(A,B,Op) with arbitrary flags.
- Reset: pulse rst_n low mid-cycle → A=B=0, Op=0, res_*=0, res_valid=0, stage=0001, all asynchronously.
- Full sequence: sw=5 + press, sw=3 + press, sw=2 + press, with the model returning R=2, flags=4'b0010 → A=5, B=3, Op=10; exactly 1 cycle after Op loads, res_R=2, res_flags=0010, res_valid=1, stage=1000.
- Bounce: btn_next toggles high for 3 cycles, low for 1, high for 2, then low → no state change. Held high for 40 cycles → exactly one advance, with LOAD_A→LOAD_B occurring 6±1 cycles after the stable rise.
- Clear priority: in LOAD_OP, btn_next and btn_clear rise together and stay stable → state LOAD_A, all registers 0, Op not loaded.
- Wrap: in SHOW, press next → res_valid drops the next cycle, stage=0001, res_R retained; a following sw=9 press loads A=9.
- Reset mid-operation: assert rst_n in LOAD_B with btn_next held → cleared. After release, the held button yields one advance to LOAD_B after ≥4 stable cycles.
